// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies NUM_BYTES bytes from page {src,8'h00} to DEST_BASE
// through memoryunit's CPU-side address/OE/WE port. Sources at or above 0xE0xx
// are folded down by 0x2000 (echo RAM).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   dma_start    one-cycle pulse for a CPU write to 0xFF46; restarts if active
//   dma_src      source high byte, sampled with dma_start
//   mem_rdata    read data from memoryunit (valid the cycle after the address)
//   mem_address  registered address to memoryunit
//   mem_oe       registered read enable
//   mem_we       registered write enable
//   mem_wdata    registered write data
//   busy         DMA owns the bus
//   done         one-cycle pulse after the final byte is written
module oam_dma_engine #(
    parameter int unsigned NUM_BYTES   = 160,
    parameter int unsigned BYTE_CYCLES = 4,
    parameter logic [15:0] DEST_BASE   = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_src,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_address,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PhW = $clog2(BYTE_CYCLES);
    localparam logic [7:0] LastIdx = 8'(NUM_BYTES - 1);
    localparam logic [PhW-1:0] LastPhase = PhW'(BYTE_CYCLES - 1);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [7:0]     src_q, src_d;
    logic [7:0]     buf_q, buf_d;
    logic [15:0]    addr_q, addr_d;
    logic           oe_q, oe_d;
    logic           we_q, we_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     src_fold;

    // Echo RAM 0xE000-0xFFFF mirrors 0xC000-0xDFFF.
    assign src_fold = (dma_src >= 8'hE0) ? dma_src - 8'h20 : dma_src;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        src_d   = src_q;
        buf_d   = buf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Read data is valid during phase 1; latch it on the edge leaving phase 1.
        if (state_q == StXfer && phase_q == PhW'(1)) begin
            buf_d = mem_rdata;
        end

        if (dma_start) begin
            // Start or restart always wins, including over a final-byte completion.
            state_d = StXfer;
            src_d   = src_fold;
            idx_d   = 8'h00;
            phase_d = '0;
            busy_d  = 1'b1;
        end else if (state_q == StXfer) begin
            if (phase_q == LastPhase) begin
                phase_d = '0;
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 8'h01;
                end
            end else begin
                phase_d = phase_q + PhW'(1);
            end
        end

        // Outputs are registered for the phase being entered, so decode from next state.
        addr_d  = addr_q;
        wdata_d = wdata_q;
        oe_d    = 1'b0;
        we_d    = 1'b0;
        if (state_d == StXfer) begin
            case (phase_d)
                PhW'(0): begin
                    addr_d = {src_d, idx_d};
                    oe_d   = 1'b1;
                end
                PhW'(1): oe_d = 1'b1;
                PhW'(2): addr_d = DEST_BASE + {8'h00, idx_d};
                PhW'(3): begin
                    we_d    = 1'b1;
                    wdata_d = buf_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= 8'h00;
            phase_q <= '0;
            src_q   <= 8'h00;
            buf_q   <= 8'h00;
            addr_q  <= 16'h0000;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            src_q   <= src_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_oe      = oe_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
module tb_oam_dma_engine;

    localparam int NUM = 160;
    localparam logic [15:0] DEST = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start;
    logic [7:0]  dma_src;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_address;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;

    oam_dma_engine dut (
        .clk        (clk),
        .rst        (rst),
        .dma_start  (dma_start),
        .dma_src    (dma_src),
        .mem_rdata  (mem_rdata),
        .mem_address(mem_address),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // memoryunit model: address registered each edge, writes use the registered address.
    logic [7:0]  mem [0:65535];
    logic [15:0] addr_reg = 16'h0000;
    assign mem_rdata = mem[addr_reg];
    always @(posedge clk) begin
        if (mem_we) mem[addr_reg] = mem_wdata;
        addr_reg <= mem_address;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         w_pop;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    logic [7:0]  cur_src = 8'h00;
    logic [15:0] prev_addr = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    // Scoreboard monitor: pops one expected write per observed write cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (busy) chk("oe_we_overlap", 32'(mem_oe & mem_we), 0);
            if (mem_we) begin
                we_cnt++;
                chk("we_addr_held", 32'(mem_address), 32'(prev_addr));
                chk("dest_window", 32'(mem_address >= DEST && mem_address < DEST + 16'(NUM)), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w_pop = exp_q.pop_front();
                    chk("write_addr", 32'(mem_address), 32'(w_pop.addr));
                    chk("write_data", 32'(mem_wdata), 32'(w_pop.data));
                end
            end
            if (mem_oe) begin
                chk("src_window",
                    32'(mem_address[15:8] == cur_src && int'(mem_address[7:0]) < NUM), 1);
            end
            prev_addr = mem_address;
        end
    end

    // Called just after a rising edge; the DMA starts on the following edge.
    task automatic start_dma(input logic [7:0] src);
        dma_src   = src;
        dma_start = 1'b1;
        @(posedge clk);
        #2;
        dma_start = 1'b0;
        cur_src = fold(src);
        exp_q.delete();
        we_cnt = 0;
        for (int i = 0; i < NUM; i++) begin
            exp_q.push_back('{addr: DEST + 16'(i), data: mem[{cur_src, 8'(i)}]});
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 2000 && busy; c++) @(posedge clk);
        chk("idle_timeout", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_oam(input string name, input logic [7:0] src, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (mem[DEST + 16'(i)] !== mem[{fold(src), 8'(i)}]) bad++;
        end
        chk(name, 32'(bad), 0);
    endtask

    task automatic full_run(input logic [7:0] src);
        busy_cnt = 0;
        done_cnt = 0;
        start_dma(src);
        wait_idle();
        chk("busy_cycles", 32'(busy_cnt), 32'(NUM * 4));
        chk("done_pulses", 32'(done_cnt), 1);
        chk("we_count", 32'(we_cnt), 32'(NUM));
        chk("queue_empty", 32'(exp_q.size()), 0);
        check_oam("oam_contents", src, NUM);
    endtask

    logic [7:0] old9;

    initial begin
        rst       = 1'b0;
        dma_start = 1'b0;
        dma_src   = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < NUM; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_oe", 32'(mem_oe), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Known pattern, echo fold, just-below-echo, random pages.
        full_run(8'hC0);
        for (int i = 0; i < NUM; i++) begin
            if (mem[DEST + 16'(i)] !== (8'(i) ^ 8'h5A)) chk("oam_pattern", 32'(i), 32'hFFFF);
        end
        full_run(8'hFE);
        full_run(8'hDF);
        full_run(8'($urandom_range(1, 8'hFD)));

        // Restart 100 cycles into a transfer.
        busy_cnt = 0;
        done_cnt = 0;
        start_dma(8'hC0);
        repeat (99) @(posedge clk);
        #2;
        start_dma(8'hC1);
        wait_idle();
        chk("restart_busy_cycles", 32'(busy_cnt), 32'(100 + NUM * 4));
        chk("restart_done_pulses", 32'(done_cnt), 1);
        chk("restart_we_count", 32'(we_cnt), 32'(NUM));
        chk("restart_queue_empty", 32'(exp_q.size()), 0);
        check_oam("restart_oam", 8'hC1, NUM);

        // Reset during byte 9.
        mem[16'hC209] = ~mem[DEST + 16'h0009];
        old9 = mem[DEST + 16'h0009];
        done_cnt = 0;
        start_dma(8'hC2);
        repeat (37) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_oe", 32'(mem_oe), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_addr", 32'(mem_address), 0);
        chk("mid_rst_wdata", 32'(mem_wdata), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        chk("mid_rst_we_count", 32'(we_cnt), 9);
        chk("mid_rst_no_done", 32'(done_cnt), 0);
        check_oam("mid_rst_oam_0_8", 8'hC2, 9);
        chk("mid_rst_byte9", 32'(mem[DEST + 16'h0009]), 32'(old9));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Page zero source.
        full_run(8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- OAM DMA controller that sits next to memoryunit on its CPU-side port.
- On a CPU write to 0xFF46, it copies 160 bytes from {src,8'h00}..{src,8'h9F} to 0xFE00..0xFE9F using memoryunit's address/OE/WE interface.
- While active it raises a bus-grant request; top-level muxing gives it the memoryunit port and stalls CPU accesses outside HRAM.

Parameters:
- NUM_BYTES, 160, bytes per transfer (1..256).
- BYTE_CYCLES, 4, clocks per byte; must be >= 4.
- DEST_BASE, 16'hFE00, destination base address.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- dma_start  input  1  one-cycle pulse: CPU write to 0xFF46.
- dma_src  input  8  written value (source high byte), sampled when dma_start=1.
- mem_rdata  input  8  read data returned by memoryunit.
- mem_address  output  16  address to memoryunit, registered.
- mem_oe  output  1  read enable, registered.
- mem_we  output  1  write enable, registered.
- mem_wdata  output  8  write data, registered; top level drives it onto the data bus when mem_we=1.
- busy  output  1  DMA owns the bus.
- done  output  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (rst=0, async): busy=0, done=0, mem_oe=0, mem_we=0, mem_address=16'h0000, mem_wdata=8'h00, idx=0, phase=0, state=IDLE.
- Memoryunit registers the address on each edge, so data is valid the cycle after an address is presented. Writes use the previously registered address, so WE follows the address by one cycle.
- States:
  - IDLE: outputs deasserted.
  - XFER: per-byte phase counter 0..BYTE_CYCLES-1.
- Start:
  - dma_start=1 at edge T latches src_eff, sets idx=0, phase=0, state=XFER, busy=1.
  - src_eff = (dma_src >= 8'hE0) ? dma_src - 8'h20 : dma_src (echo fold).
- Per-byte phase outputs during XFER; each phase's outputs are registered for that cycle:
  - Phase 0: mem_address = {src_eff, idx}, mem_oe=1, mem_we=0.
  - Phase 1: address held, mem_oe=1; at the end-of-phase edge, capture mem_rdata into a byte buffer.
  - Phase 2: mem_address = DEST_BASE + idx, mem_oe=0, mem_we=0.
  - Phase 3: address held, mem_we=1, mem_wdata = buffer.
  - Phases 4..BYTE_CYCLES-1: all enables 0, address held.
- Advance:
  - After the last phase, idx increments and phase returns to 0.
  - After the last phase of idx = NUM_BYTES-1: state=IDLE, busy=0, done=1 for exactly one cycle, all enables 0.
- Latency: busy is high for exactly NUM_BYTES*BYTE_CYCLES cycles (640 by default). done rises on the edge after the final write cycle.
- Restart: dma_start during XFER aborts the current byte and restarts at idx=0 with the new src. done is not pulsed for the aborted transfer, and busy stays high.
- Simultaneous final phase and dma_start: the restart wins; done=0.
- mem_we and mem_oe are never both 1. No writes occur outside DEST_BASE..DEST_BASE+NUM_BYTES-1.
- idx is 8 bits. Address arithmetic is 16 bits with no carry beyond bit 15.
- Reset mid-transfer: immediate return to reset values. A write is not completed.

Test Plan:
- Preload 0xC000..0xC09F with (i^8'h5A); pulse dma_start with dma_src=8'hC0 -> busy high 640 cycles, OAM[i] == i^8'h5A for all i, single done pulse, mem_we asserted exactly 160 times.
- dma_src=8'hFE -> source reads come from 0xDE00..0xDE9F (echo fold); 8'hDF -> reads from 0xDF00 (no fold).
- Pulse dma_start(8'hC0), then dma_start(8'hC1) at cycle 100 -> restart at idx 0, OAM matches 0xC100 data, busy continuous for 100+640 cycles, one done pulse.
- Assert rst=0 at cycle 37 of a transfer -> all outputs 0 in the same cycle, no done, OAM bytes 0..8 written and byte 9 untouched.
- Protocol checker over a full transfer -> mem_we cycles always preceded by one cycle with the same address; oe and we never overlap; address is never outside the source/destination windows.
- Edge case: dma_start with dma_src=8'h00 -> reads 0x0000..0x009F (boot ROM or ROM0 per memoryunit decode); the copy completes normally.
